// File: rtl/hp_damage_fsm_if.sv
// hp_damage_fsm_if: frame/tile inputs and health outputs of the player health controller.
interface hp_damage_fsm_if;
  logic       vsync;
  logic [3:0] current_pix;
  logic       restart;
  logic [3:0] hp;
  logic       dead;
  logic       blink;
  logic       hit_pulse;
  modport master (output vsync, current_pix, restart, input hp, dead, blink, hit_pulse);
  modport slave  (input vsync, current_pix, restart, output hp, dead, blink, hit_pulse);
endinterface

// File: rtl/hp_damage_fsm.sv
// hp_damage_fsm: per-frame player health with hazard damage, invulnerability window and edge-triggered healing.
module hp_damage_fsm #(
  parameter int         HP_MAX        = 5,
  parameter int         INVULN_FRAMES = 60,
  parameter logic [3:0] HAZARD_CODE   = 4'h3,
  parameter logic [3:0] HEAL_CODE     = 4'h5,
  parameter int         BLINK_BIT     = 2
) (
  input logic            clk,
  input logic            rst,
  hp_damage_fsm_if.slave bus
);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int FW = BLINK_BIT + 1;
  localparam logic [3:0]    HPM      = 4'(HP_MAX);
  localparam logic [IW-1:0] INV_INIT = IW'(INVULN_FRAMES);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
  state_t        state, state_n;
  logic [3:0]    hp, hp_n;
  logic [IW-1:0] inv_cnt, inv_n;
  logic [FW-1:0] frame_cnt;
  logic          heal_prev, heal_n, hit_pulse, hit_n, vsync_q, tick, is_heal, is_hazard;
  assign tick      = bus.vsync & ~vsync_q;
  assign is_heal   = bus.current_pix == HEAL_CODE;
  assign is_hazard = bus.current_pix == HAZARD_CODE;
  always_comb begin
    state_n = state;
    hp_n    = hp;
    inv_n   = inv_cnt;
    heal_n  = heal_prev;
    hit_n   = 1'b0;
    if (bus.restart) begin
      state_n = ALIVE;
      hp_n    = HPM;
      inv_n   = '0;
      heal_n  = 1'b0;
    end else if (tick && state != DEAD) begin
      heal_n = is_heal;
      if (is_heal && !heal_prev && hp < HPM) hp_n = hp + 4'd1;
      if (state == ALIVE && is_hazard) begin
        hp_n    = hp - 4'd1;
        hit_n   = 1'b1;
        state_n = hp == 4'd1 ? DEAD : INVULN;
        inv_n   = hp == 4'd1 ? '0 : INV_INIT;
      end else if (state == INVULN) begin
        state_n = inv_cnt == IW'(1) ? ALIVE : INVULN;
        inv_n   = inv_cnt - IW'(1);
      end
    end
  end
  // vsync_q resets high so a vsync already high at reset release is not a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ALIVE;
      hp        <= HPM;
      inv_cnt   <= '0;
      frame_cnt <= '0;
      heal_prev <= 1'b0;
      hit_pulse <= 1'b0;
      vsync_q   <= 1'b1;
    end else begin
      state     <= state_n;
      hp        <= hp_n;
      inv_cnt   <= inv_n;
      heal_prev <= heal_n;
      hit_pulse <= hit_n;
      vsync_q   <= bus.vsync;
      frame_cnt <= bus.restart ? '0 : frame_cnt + FW'(tick);
    end
  end
  assign bus.hp        = hp;
  assign bus.dead      = state == DEAD;
  assign bus.blink     = state == INVULN && frame_cnt[BLINK_BIT];
  assign bus.hit_pulse = hit_pulse;
endmodule

// File: doc/hp_damage_fsm.md
# hp_damage_fsm

Frame-synchronous player health controller for the game screen. Each frame it samples the 4-bit map tile code under the player. It applies damage on hazard tiles with a post-hit invulnerability window and heals on heart tiles. It drives the HP digit and the game-over overlay stages downstream, plus a blink flag for the player sprite stage.

## Interface
Parameters:
- HP_MAX, 5: reset/restart health; 1..15.
- INVULN_FRAMES, 60: frames of immunity after a hit; ≥1.
- HAZARD_CODE, 4'h3: tile code that deals damage.
- HEAL_CODE, 4'h5: tile code that restores health.
- BLINK_BIT, 2: frame-counter bit that drives blink; < counter width.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- vsync, input, 1: VGA vsync from the timing path; its rising edge marks the frame tick.
- current_pix, input, 4: tile code under the player, from the map ROM.
- restart, input, 1: synchronous level; returns the block to a fresh game.
- hp, output, 4: current health, 0..HP_MAX.
- dead, output, 1: high while in DEAD.
- blink, output, 1: sprite-hide request during invulnerability.
- hit_pulse, output, 1: one-cycle strobe on each applied hit.

## Operation
- Frame tick: `tick = vsync & ~vsync_q`, where vsync_q is a registered copy of vsync. All game updates except restart happen only on tick cycles.
- The block samples current_pix on tick cycles only. It also keeps heal_prev, which records whether the previous tick's sample equalled HEAL_CODE.
- The state machine has three states: ALIVE, INVULN, DEAD.
- ALIVE, tick, sample == HAZARD_CODE:
  - hp ← hp−1, hit_pulse ← 1.
  - If the new hp is 0, go to DEAD.
  - Otherwise go to INVULN with inv_cnt ← INVULN_FRAMES.
- INVULN, tick:
  - Hazard samples are ignored.
  - If inv_cnt == 1, go to ALIVE with inv_cnt ← 0. Otherwise inv_cnt ← inv_cnt−1.
- Heal applies in ALIVE or INVULN on a tick when all hold:
  - sample == HEAL_CODE;
  - heal_prev == 0 (entry edge, so one heal per visit);
  - hp < HP_MAX.
  - Effect: hp ← hp+1.
  - Heal never coincides with a hit, because the two codes differ.
- DEAD: hp holds at 0, all ticks are ignored, dead = 1.
- restart (any state, any cycle, highest priority):
  - hp ← HP_MAX, state ← ALIVE.
  - inv_cnt, frame_cnt and heal_prev ← 0.
  - hit_pulse ← 0.
- frame_cnt is a free-running counter that increments on every tick.
  - blink = (state == INVULN) & frame_cnt[BLINK_BIT].
  - blink is 0 in ALIVE and DEAD.
- Widths:
  - inv_cnt is $clog2(INVULN_FRAMES+1) bits.
  - frame_cnt is at least BLINK_BIT+1 bits and wraps silently.
  - hp never underflows below 0 or exceeds HP_MAX.

## Timing
- Reset values:
  - hp = HP_MAX, state = ALIVE.
  - dead, blink, hit_pulse = 0.
  - inv_cnt, frame_cnt, heal_prev = 0.
  - vsync_q = 1, so no spurious tick occurs if vsync is high at reset release.
- Latency: hp, dead and hit_pulse update at the clock edge that ends the tick cycle. That is one clk after vsync is first sampled high.
- hit_pulse is high for exactly one cycle per hit and 0 on every other cycle.
- Invulnerability covers exactly INVULN_FRAMES ticks after the hit tick. The tick on which inv_cnt == 1 still ignores hazards; the following tick can hit again.
- If restart and tick occur in the same cycle, restart wins and the tick is discarded, including the frame_cnt increment.
- If rst is asserted mid-INVULN, everything clears immediately (asynchronously).
- Outputs are registered; blink may be a registered AND or combinational from registered state.

## Test plan
- Reset, then 3 vsync pulses with current_pix = 0:
  - hp stays 5, dead = 0, hit_pulse never asserts.
- current_pix = 3 held for 70 frames (INVULN_FRAMES = 60):
  - first hit at frame 1 → hp = 4;
  - next hit at frame 62 → hp = 3;
  - exactly 2 hit_pulse strobes;
  - blink toggles every 4 frames while in INVULN.
- Hazard hits repeated until hp = 0:
  - dead = 1, hp = 0;
  - further hazard and heal frames leave hp = 0;
  - restart → hp = 5, dead = 0 on the next edge.
- From hp = 3, current_pix = 5 held for 10 frames:
  - hp = 4 after the first tick only;
  - leave the tile for one frame and re-enter → hp = 5;
  - re-entering at hp = 5 → hp stays 5.
- restart asserted in the same cycle as a hazard tick:
  - hp = 5, state ALIVE, hit_pulse = 0.
- rst pulse mid-INVULN while vsync is high:
  - all outputs return to reset values;
  - no tick fires until vsync goes low and then high again.
